// File: rtl/mdu_seq_if.sv
// mdu_seq_if: issue/result bundle between the main controller and the
// multiply/divide sequencer. Signal names follow the MDU port list.
interface mdu_seq_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             abort;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, abort, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, abort, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_seq.sv
// mdu_seq: iterative multiply/divide sequencer holding the architectural
// HI/LO registers. MULT/MULTU use shift-add and DIV/DIVU use restoring
// division, one bit per cycle over operand magnitudes, with the sign fixed
// in a final FIX cycle. Optional macro MDU_FAST_MUL_EN replaces the
// iterative multiply with a single-cycle combinational multiplier.
module mdu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input logic       clk,
  input logic       reset,
  mdu_seq_if.slave  mdu
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;   // partial product high / remainder
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;   // multiplier / dividend -> quotient
  logic [WIDTH-1:0] opnd_q, opnd_d;       // multiplicand / divisor magnitude
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;         // product/quotient needs negation
  logic             sa_q, sa_d;           // dividend was negative
  logic             div0_q, div0_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             issue_c, mt_c, op_div_c, a_neg_c, b_neg_c;
  logic [WIDTH-1:0] a_mag_c, b_mag_c;
  logic [WIDTH:0]   mul_sum_c, div_rem_c;
  logic [WIDTH-1:0] div_sub_c;
  logic             div_ge_c;
  logic [PW-1:0]    prod_c;
  logic [WIDTH-1:0] fix_hi_c, fix_lo_c;
`ifdef MDU_FAST_MUL_EN
  logic [PW-1:0]    prod_fast_c;
`endif

  // Operand decode, magnitudes and one iteration step of each datapath
  always_comb begin
    issue_c   = mdu.start && !mdu.abort && !mdu.op[2];
    mt_c      = mdu.start && !mdu.abort && mdu.op[2] && !mdu.op[1];
    op_div_c  = mdu.op[1];
    a_neg_c   = !mdu.op[0] && mdu.a[WIDTH-1];
    b_neg_c   = !mdu.op[0] && mdu.b[WIDTH-1];
    a_mag_c   = a_neg_c ? (~mdu.a + WIDTH'(1)) : mdu.a;
    b_mag_c   = b_neg_c ? (~mdu.b + WIDTH'(1)) : mdu.b;
    mul_sum_c = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    div_rem_c = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge_c  = div_rem_c >= {1'b0, opnd_q};
    div_sub_c = WIDTH'(div_rem_c - {1'b0, opnd_q});
`ifdef MDU_FAST_MUL_EN
    prod_fast_c = {{WIDTH{1'b0}}, a_mag_c} * {{WIDTH{1'b0}}, b_mag_c};
`endif
  end

  // Sign correction of the finished magnitude result
  always_comb begin
    prod_c   = {acc_hi_q, acc_lo_q};
    fix_hi_c = acc_hi_q;
    fix_lo_c = acc_lo_q;
    if (!is_div_q) begin
      if (neg_q) prod_c = ~prod_c + PW'(1);
      fix_hi_c = prod_c[PW-1:WIDTH];
      fix_lo_c = prod_c[WIDTH-1:0];
    end else if (div0_q) begin
      // a zero divisor shifts the whole dividend magnitude into the remainder
      fix_hi_c = sa_q ? (~acc_hi_q + WIDTH'(1)) : acc_hi_q;
      fix_lo_c = {WIDTH{1'b1}};
    end else begin
      fix_hi_c = sa_q ? (~acc_hi_q + WIDTH'(1)) : acc_hi_q;
      fix_lo_c = neg_q ? (~acc_lo_q + WIDTH'(1)) : acc_lo_q;
    end
  end

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      sa_q     <= 1'b0;
      div0_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      sa_q     <= sa_d;
      div0_q   <= div0_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Next-state, iteration and HI/LO commit
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    sa_d     = sa_q;
    div0_d   = div0_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        if (issue_c) begin
          acc_hi_d = '0;
          acc_lo_d = op_div_c ? a_mag_c : b_mag_c;
          opnd_d   = op_div_c ? b_mag_c : a_mag_c;
          is_div_d = op_div_c;
          neg_d    = a_neg_c ^ b_neg_c;
          sa_d     = a_neg_c;
          div0_d   = (mdu.b == '0);
          count_d  = '0;
          state_d  = CALC;
`ifdef MDU_FAST_MUL_EN
          if (!op_div_c) begin
            {acc_hi_d, acc_lo_d} = prod_fast_c;
            state_d = FIX;
          end
`endif
        end else if (mt_c) begin
          if (mdu.op[0]) lo_d = mdu.a;
          else           hi_d = mdu.a;
        end
      end
      CALC: begin
        if (mdu.abort) begin
          state_d = IDLE;
        end else begin
          if (is_div_q) begin
            acc_hi_d = div_ge_c ? div_sub_c : div_rem_c[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge_c};
          end else begin
            acc_hi_d = mul_sum_c[WIDTH:1];
            acc_lo_d = {mul_sum_c[0], acc_lo_q[WIDTH-1:1]};
          end
          count_d = count_q + CW'(1);
          if (count_q == CW'(WIDTH - 1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!mdu.abort) begin
          done_d = 1'b1;
          hi_d   = fix_hi_c;
          lo_d   = fix_lo_c;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign mdu.busy = busy_q;
  assign mdu.done = done_q;
  assign mdu.hi   = hi_q;
  assign mdu.lo   = lo_q;
endmodule
